// File: rtl/bomb_stock.sv
// Player bomb inventory: credits bonus pickups, spends a bomb on key press to
// clear all enemies, and draws the flash / HUD overlay layer.
module bomb_stock #(
    parameter int                 MAX_BOMBS    = 3,
    parameter int                 CNT_BIT_LEN  = 2,
    parameter int                 INIT_BOMBS   = 1,
    parameter int                 FLASH_FRAMES = 8,
    parameter int                 H_LEN        = 10,
    parameter int                 V_LEN        = 10,
    parameter int                 RGB_W        = 12,
    parameter int                 HUD_X        = 8,
    parameter int                 HUD_Y        = 8,
    parameter int                 HUD_SIZE     = 8,
    parameter int                 HUD_PITCH    = 12,
    parameter logic [RGB_W-1:0]   FLASH_COLOR  = 12'hFFF,
    parameter logic [RGB_W-1:0]   HUD_COLOR    = 12'hF80
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   crash_me_bonus_i,
    input  logic                   use_key_i,
    input  logic                   v_sync_i,
    input  logic [H_LEN-1:0]       req_x_addr_i,
    input  logic [V_LEN-1:0]       req_y_addr_i,
    output logic [CNT_BIT_LEN-1:0] bomb_cnt_o,
    output logic                   clear_all_o,
    output logic                   flash_active_o,
    output logic                   vga_alpha_o,
    output logic [RGB_W-1:0]       vga_rgb_o
);

    typedef enum logic {IDLE, FLASH} state_t;

    localparam int FW = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(FLASH_FRAMES - 1);

    logic                   s1, s2, s3;
    logic                   crash_prev, vs_prev, lock;
    logic                   press, vs_rise, pick, do_use;
    state_t                 state, state_next;
    logic [FW-1:0]          frame_cnt, frame_cnt_next;
    logic [CNT_BIT_LEN-1:0] cnt, cnt_next;
    logic [CNT_BIT_LEN:0]   cnt_sum;
    logic                   clear_next;
    logic                   hud_hit, ov_alpha;
    logic [RGB_W-1:0]       ov_rgb;
    int                     x_pos, y_pos;

    assign press   = s2 & ~s3;
    assign vs_rise = v_sync_i & ~vs_prev;
    assign pick    = en_i & crash_me_bonus_i & ~crash_prev & ~lock;
    // Gated on the pre-update stock, so an empty stock rejects the use even
    // when a pickup lands on the same edge.
    assign do_use  = en_i & press & (state == IDLE) & (cnt != '0);

    always_comb begin
        cnt_sum = {1'b0, cnt} + {{CNT_BIT_LEN{1'b0}}, pick} - {{CNT_BIT_LEN{1'b0}}, do_use};
        if (cnt_sum > (CNT_BIT_LEN+1)'(MAX_BOMBS))
            cnt_next = CNT_BIT_LEN'(MAX_BOMBS);
        else
            cnt_next = cnt_sum[CNT_BIT_LEN-1:0];
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        clear_next     = 1'b0;
        if (!en_i) begin
            state_next     = IDLE;
            frame_cnt_next = '0;
        end else begin
            unique case (state)
                IDLE: if (do_use) begin
                    state_next     = FLASH;
                    frame_cnt_next = '0;
                    clear_next     = 1'b1;
                end
                FLASH: if (vs_rise) begin
                    if (frame_cnt == LAST_FRAME) begin
                        state_next     = IDLE;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign x_pos = int'(req_x_addr_i);
    assign y_pos = int'(req_y_addr_i);

    always_comb begin
        hud_hit  = 1'b0;
        ov_alpha = 1'b0;
        ov_rgb   = '0;
        for (int j = 0; j < MAX_BOMBS; j++) begin
            if (j < int'(cnt) &&
                x_pos >= HUD_X + j*HUD_PITCH && x_pos < HUD_X + j*HUD_PITCH + HUD_SIZE &&
                y_pos >= HUD_Y && y_pos < HUD_Y + HUD_SIZE)
                hud_hit = 1'b1;
        end
        // Flash blinks on even frames and covers the HUD.
        if (state == FLASH && !frame_cnt[0]) begin
            ov_alpha = 1'b1;
            ov_rgb   = FLASH_COLOR;
        end else if (hud_hit) begin
            ov_alpha = 1'b1;
            ov_rgb   = HUD_COLOR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            crash_prev  <= 1'b0;
            vs_prev     <= 1'b0;
            lock        <= 1'b0;
            cnt         <= CNT_BIT_LEN'(INIT_BOMBS);
            state       <= IDLE;
            frame_cnt   <= '0;
            clear_all_o <= 1'b0;
            vga_alpha_o <= 1'b0;
            vga_rgb_o   <= '0;
        end else begin
            s1          <= use_key_i;
            s2          <= s1;
            s3          <= s2;
            crash_prev  <= crash_me_bonus_i;
            vs_prev     <= v_sync_i;
            if (pick)
                lock <= 1'b1;
            else if (vs_rise)
                lock <= 1'b0;
            if (en_i)
                cnt <= cnt_next;
            state       <= state_next;
            frame_cnt   <= frame_cnt_next;
            clear_all_o <= clear_next;
            vga_alpha_o <= ov_alpha;
            vga_rgb_o   <= ov_rgb;
        end
    end

    assign bomb_cnt_o     = cnt;
    assign flash_active_o = (state == FLASH);

endmodule

// File: doc/bomb_stock.md
# bomb_stock

Player-side bomb inventory and screen-clear controller, downstream of the bomb bonus sprite block. Consumes the bomb block's `crash_me_bonus_i` pickup strobe and credits one bomb per pickup, up to a saturating limit. Consumes the player's bomb key and, when stock is available, issues a one-cycle `clear_all_o` strobe to the enemy blocks. Produces a VGA overlay layer containing a full-screen blink during the clear and HUD icons that show the remaining stock.

## Interface
Parameters:
- `MAX_BOMBS`, 3: saturation limit of the stock.
- `CNT_BIT_LEN`, 2: width of the stock counter; must satisfy `2^CNT_BIT_LEN > MAX_BOMBS`.
- `INIT_BOMBS`, 1: stock value loaded at reset.
- `FLASH_FRAMES`, 8: duration of the flash, counted in frames (≥2).
- `H_LEN`, 10: width of the x request address.
- `V_LEN`, 10: width of the y request address.
- `RGB_W`, 12: colour width.
- `HUD_X`, 8: x origin of the HUD icons.
- `HUD_Y`, 8: y origin of the HUD icons.
- `HUD_SIZE`, 8: edge length of each square icon.
- `HUD_PITCH`, 12: x spacing between consecutive icons.
- `FLASH_COLOR`, 12'hFFF: overlay colour during flash frames.
- `HUD_COLOR`, 12'hF80: icon colour.

Ports:
- `clk_vga` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `en_i` in 1: game running.
- `crash_me_bonus_i` in 1: player/bomb-bonus collision level, synchronous to `clk_vga`.
- `use_key_i` in 1: raw, asynchronous bomb key, active high.
- `v_sync_i` in 1: frame sync.
- `req_x_addr_i` in `H_LEN`: pixel x being requested.
- `req_y_addr_i` in `V_LEN`: pixel y being requested.
- `bomb_cnt_o` out `CNT_BIT_LEN`: current stock.
- `clear_all_o` out 1: one-cycle strobe that kills all on-screen enemies.
- `flash_active_o` out 1: high while the FSM is in FLASH.
- `vga_alpha_o` out 1: overlay pixel is opaque.
- `vga_rgb_o` out `RGB_W`: overlay colour.

## Operation
- Key path:
  - `use_key_i` passes through a 2-FF synchroniser (s1, s2) followed by a history FF s3.
  - `press = s2 & ~s3`.
- Frame tick: `vs_rise = v_sync_i & ~vs_prev`.
- Pickup:
  - `pick = en_i & crash_me_bonus_i & ~crash_prev & ~lock`.
  - `pick` sets `lock`. `vs_rise` clears `lock`, so at most one credit is given per frame.
- Use:
  - `use = en_i & press & (state==IDLE) & (cnt != 0)`.
  - The `cnt` tested is the value before this cycle's update.
- Stock update, in the same edge:
  - `cnt_next = cnt - use + pick`, then saturated to `MAX_BOMBS`.
  - Simultaneous `pick` and `use` with `cnt>0`: cnt is unchanged, and the clear still fires.
  - `cnt==0` with both: `use` is rejected and cnt becomes 1.
- FSM states: IDLE and FLASH.
  - IDLE → FLASH on `use`. At the same time `frame_cnt` is set to 0 and `clear_all_o` is registered to 1.
  - In FLASH, each `vs_rise` increments `frame_cnt`.
  - FLASH → IDLE on `vs_rise` when `frame_cnt == FLASH_FRAMES-1`.
  - Key presses in FLASH are ignored. They are not queued.
  - Pickups in FLASH are credited normally.
- `en_i` low:
  - The FSM is forced to IDLE, `frame_cnt` is cleared, and `clear_all_o` is 0.
  - `cnt` holds its value, and pickup and use are suppressed.
- Overlay, priority high to low:
  - In FLASH with `frame_cnt[0]==0`: alpha=1 and rgb=`FLASH_COLOR` for every pixel.
  - Icon j, for j < cnt, occupies `HUD_X+j*HUD_PITCH ≤ x < HUD_X+j*HUD_PITCH+HUD_SIZE` and `HUD_Y ≤ y < HUD_Y+HUD_SIZE`. A pixel inside such an icon gets alpha=1 and rgb=`HUD_COLOR`.
  - All other pixels get alpha=0 and rgb=0.
- Reset values:
  - Counter: `bomb_cnt_o=INIT_BOMBS`.
  - Status outputs: `clear_all_o=0`, `flash_active_o=0`.
  - Overlay outputs: `vga_alpha_o=0`, `vga_rgb_o=0`.
  - State: IDLE. Internal registers: `lock`, s1–s3, `crash_prev`, `vs_prev` and `frame_cnt` all 0.
  - A reset mid-FLASH aborts the flash immediately.

## Timing
- Every output is registered.
- Key latency, with `use_key_i` first sampled high at edge E:
  - `clear_all_o=1`, decremented `bomb_cnt_o` and `flash_active_o=1` are visible after E+2.
  - `clear_all_o` returns to 0 after E+3, giving exactly one cycle high.
- Holding the key produces no further strobes. A release and a new press are required.
- Pickup latency: `crash_me_bonus_i` rises before edge E → `bomb_cnt_o` is incremented after E.
- Overlay latency is 1 cycle: the pixel for the address presented before edge E appears after E. The video mux compensates.
- Flash length is `FLASH_FRAMES` `vs_rise` events. `flash_active_o` falls on the edge that samples the final `vs_rise`.

## Test plan
1. Reset: assert `rst` async mid-cycle → outputs immediately `bomb_cnt_o=1`, `clear_all_o=0`, `flash_active_o=0`, `vga_alpha_o=0`.
2. Pickup and saturation: en_i=1; give 4 separate crash pulses, each in a different frame → cnt goes 2,3,3,3. Hold crash high for 50 cycles within one frame → exactly one credit.
3. Use: cnt=2; key high for 100 cycles → exactly one `clear_all_o` pulse at E+2, cnt=1, FLASH entered. After 8 `vs_rise` → IDLE, and alpha is high only in frames 0, 2, 4 and 6.
4. Empty stock: cnt=0, press key → no strobe and state stays IDLE. In the same cycle as a press, a crash rise gives cnt=1 with no clear.
5. Simultaneous: cnt=3, press edge and crash rise on the same edge → cnt=3 and `clear_all_o` pulses.
6. HUD and en_i: cnt=2, idle; pixel (8,8) → alpha=1, rgb=F80. Pixel (20,8) → alpha=1. Pixel (32,8) → alpha=0. Drop `en_i` mid-FLASH → IDLE next edge, cnt held.
